// File: rtl/game_status_ctrl.sv
// game_status_ctrl: snake game state, score, speed level and move tick; define GAME_HIGH_SCORE_EN for the high-score register
module game_status_ctrl #(
  parameter int POINTS_PER_FOOD = 1,
  parameter int SCORE_MAX = 9999,
  parameter int LEVEL_FOODS = 5,
  parameter int TICK_BASE = 25_000_000,
  parameter int TICK_STEP = 2_500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        food_eaten,
  input  logic        collision,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic [2:0]  level,
`ifdef GAME_HIGH_SCORE_EN
  output logic [15:0] high_score,
`endif
  output logic        move_tick
);
  localparam int FW = LEVEL_FOODS > 1 ? $clog2(LEVEL_FOODS) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;
  state_t state, next_state;
  logic prev_start, prev_pause;
  logic [15:0] cur_score;
  logic [FW-1:0] food_cnt;
  logic [31:0] tick_cnt, period;
  logic [16:0] sum;
  logic start_edge, pause_edge, restart, run_go, tick_due, food_ok, food_wrap;
  assign start_edge = btn_start & ~prev_start;
  assign pause_edge = btn_pause & ~prev_pause;
  assign period = 32'(TICK_BASE) - 32'(level) * 32'(TICK_STEP);
  assign tick_due = tick_cnt >= period - 32'd1;
  assign restart = (state == IDLE || state == OVER) && next_state == RUN;
  assign run_go = state == RUN && next_state == RUN;
  assign food_ok = state == RUN && food_eaten && !collision;
  assign food_wrap = food_cnt == FW'(LEVEL_FOODS - 1);
  assign sum = {1'b0, cur_score} + 17'(POINTS_PER_FOOD);
  assign game_state = state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE, OVER: next_state = start_edge ? RUN : state;
      RUN:        next_state = collision ? OVER : pause_edge ? PAUSE : RUN;
      PAUSE:      next_state = pause_edge ? RUN : PAUSE;
      default:    next_state = state;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      prev_start <= 1'b0;
      prev_pause <= 1'b0;
      cur_score <= '0;
      level <= '0;
      food_cnt <= '0;
      tick_cnt <= '0;
      move_tick <= 1'b0;
    end else begin
      state <= next_state;
      prev_start <= btn_start;
      prev_pause <= btn_pause;
      move_tick <= run_go && tick_due;
      if (restart) begin
        cur_score <= '0;
        level <= '0;
        food_cnt <= '0;
        tick_cnt <= '0;
      end else begin
        if (food_ok) begin
          cur_score <= sum > 17'(SCORE_MAX) ? 16'(SCORE_MAX) : sum[15:0];
          food_cnt <= food_wrap ? '0 : food_cnt + FW'(1);
          if (food_wrap && level != 3'd7) level <= level + 3'd1;
        end
        // Count is frozen across a pause and zeroed only once the game is idle/over
        tick_cnt <= run_go ? (tick_due ? '0 : tick_cnt + 32'd1) :
                    (state == RUN || state == PAUSE) ? tick_cnt : '0;
      end
    end
  end
`ifdef GAME_HIGH_SCORE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) high_score <= '0;
    else if (state == RUN && next_state == OVER && cur_score > high_score) high_score <= cur_score;
  end
  assign score = state == IDLE ? high_score : cur_score;
`else
  assign score = cur_score;
`endif
endmodule
